a_rom_sequencer: RTL and testbench

A_ROM_SEQUENCER -- requirements
Module: a_rom_sequencer

---
 rtl/a_rom_sequencer_pkg.sv | 16 +
 rtl/a_rom_sequencer_seq_fifo.sv | 57 +++++
 rtl/a_rom_sequencer.sv | 120 ++++++++++++
 tb/tb_a_rom_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/a_rom_sequencer_pkg.sv
// Shared matrix constants and sequencer state encoding.
// Packed ROM words carry two ELEM_W-bit column elements.
package a_rom_sequencer_pkg;

    localparam int NUM_WORDS = 16;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 14;
    localparam int ELEM_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/a_rom_sequencer_seq_fifo.sv
// Synchronous FIFO with occupancy count; read data is combinational from the head entry.
// Latency: a push is visible on o_vld next cycle. Push when full and pop when empty are dropped.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_dat,
    input  logic             i_pop,
    output logic [W-1:0]     o_dat,
    output logic             o_vld,
    output logic [CNT_W-1:0] o_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push = i_push && (r_cnt != CNT_W'(DEPTH));
    assign w_pop  = i_pop && o_vld;
    assign o_vld  = (r_cnt != '0);
    assign o_cnt  = r_cnt;
    // Zero the output while empty so idle outputs match their reset values.
    assign o_dat  = o_vld ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/a_rom_sequencer.sv
// Streams NUM_WORDS packed words from a registered ROM into a valid/ready output; first word 3 cycles after start.
// Reads are issued only while buffered plus in-flight words fit in the FIFO, so out_ready stalls never drop data.
module a_rom_sequencer #(
    parameter int NUM_WORDS  = a_rom_sequencer_pkg::NUM_WORDS,
    parameter int ADDR_W     = a_rom_sequencer_pkg::ADDR_W,
    parameter int DATA_W     = a_rom_sequencer_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    import a_rom_sequencer_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TOT_W = CNT_W + 2;
    localparam int ISS_W = $clog2(NUM_WORDS + 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_W-1:0]        r_rom_addr;
    logic [ADDR_W-1:0]        r_idx_dat;
    logic                     r_vld_iss;
    logic                     r_vld_dat;
    logic [ISS_W-1:0]         r_issued;
    logic                     w_start_acc;
    logic                     w_pop;
    logic                     w_last_acc;
    logic                     w_issue;
    logic [TOT_W-1:0]         w_total;
    logic [CNT_W-1:0]         w_fifo_cnt;
    logic [DATA_W+ADDR_W-1:0] w_fifo_dat;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_pop       = out_valid && out_ready;
    assign w_last_acc  = w_pop && (out_idx == ADDR_W'(NUM_WORDS - 1));

    // Slots committed next cycle: buffered + both pipeline stages, less the word leaving now.
    assign w_total = TOT_W'(w_fifo_cnt) + TOT_W'(r_vld_iss) + TOT_W'(r_vld_dat) - TOT_W'(w_pop);
    assign w_issue = (r_state == ST_RUN) && (r_issued < ISS_W'(NUM_WORDS)) &&
                     (w_total < TOT_W'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (w_last_acc) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rom_addr <= '0;
            r_idx_dat  <= '0;
            r_vld_iss  <= 1'b0;
            r_vld_dat  <= 1'b0;
            r_issued   <= '0;
        end else begin
            r_vld_dat <= r_vld_iss;
            r_idx_dat <= r_rom_addr;
            if (w_start_acc) begin
                r_rom_addr <= '0;
                r_vld_iss  <= 1'b1;
                r_issued   <= ISS_W'(1);
            end else begin
                r_vld_iss <= w_issue;
                if (w_issue) begin
                    r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    r_issued   <= r_issued + ISS_W'(1);
                end
            end
        end
    end

    seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W + ADDR_W)
    ) u_seq_fifo (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_push     (r_vld_dat),
        .i_push_dat ({rom_data, r_idx_dat}),
        .i_pop      (w_pop),
        .o_dat      (w_fifo_dat),
        .o_vld      (out_valid),
        .o_cnt      (w_fifo_cnt)
    );

    assign rom_addr = r_rom_addr;
    assign out_data = w_fifo_dat[ADDR_W +: DATA_W];
    assign out_idx  = w_fifo_dat[ADDR_W-1:0];

endmodule

// File: tb/tb_a_rom_sequencer.sv
// Scoreboard bench for a_rom_sequencer: expected words queued at start, popped on each accept.
module tb_a_rom_sequencer;
    import a_rom_sequencer_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [ADDR_W-1:0] idx;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rom_mem [NUM_WORDS];
    exp_t              sb[$];
    int                n_asserts = 0;
    int                n_fail    = 0;

    a_rom_sequencer #(
        .NUM_WORDS  (NUM_WORDS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    function automatic exp_t model(input int i);
        exp_t e;
        e.dat = {ELEM_W'(2 * i), ELEM_W'(2 * i + 1)};
        e.idx = ADDR_W'(i);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_vld"},  out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Called at a negedge. mode 0: ready high, 1: ready low for 'hold' cycles, 2: random ready.
    task automatic run_pass(input int mode, input int hold, input bit poke,
                            input int abort_idx, input bit chain);
        int   first_vld, first_acc, last_acc, n_acc;
        bit   rdy, stall, got_done;
        logic [DATA_W+ADDR_W-1:0] held;
        exp_t e;

        sb.delete();
        for (int i = 0; i < NUM_WORDS; i++) sb.push_back(model(i));
        first_vld = -1; first_acc = -1; last_acc = -1; n_acc = 0;
        stall = 1'b0; got_done = 1'b0; held = '0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_run", busy, 1);

        for (int lat = 1; lat < 600; lat++) begin
            if (lat > 1) @(negedge clk);
            if (stall) begin
                check("stall_vld", out_valid, 1);
                check("stall_dat", {out_data, out_idx}, held);
            end
            if (out_valid && first_vld < 0) first_vld = lat;
            if (done) begin
                got_done = 1'b1;
                check("done_not_busy", busy, 0);
                check("sb_empty", sb.size(), 0);
                check("n_acc", n_acc, NUM_WORDS);
                if (mode == 0) begin
                    check("done_lat", lat, last_acc + 1);
                    check("burst_len", last_acc - first_acc, NUM_WORDS - 1);
                end
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (lat > hold);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = poke && (lat == 6);
            if (mode == 1 && (lat == hold || lat == hold - 4)) begin
                check("hold_addr", rom_addr, 3);
                check("hold_head_idx", out_idx, 0);
            end
            stall = out_valid && !rdy;
            held  = {out_data, out_idx};
            if (out_valid && rdy) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("dat", out_data, e.dat);
                    check("idx", out_idx, e.idx);
                end
                if (mode == 0 && out_idx == 3) check("word3", out_data, 14'h0307);
                if (first_acc < 0) first_acc = lat;
                last_acc = lat;
                n_acc++;
                if (out_idx == abort_idx) begin
                    @(posedge clk);
                    #1 rst = 1'b0;
                    #1;
                    check("arst_vld",  out_valid, 0);
                    check("arst_dat",  out_data, 0);
                    check("arst_idx",  out_idx, 0);
                    check("arst_addr", rom_addr, 0);
                    check("arst_busy", busy, 0);
                    check("arst_done", done, 0);
                    sb.delete();
                    repeat (2) @(negedge clk);
                    rst = 1'b1;
                    for (int t = 0; t < 6; t++) begin
                        @(negedge clk);
                        check_idle_outputs("post_arst");
                    end
                    return;
                end
            end
        end

        check("done_seen", got_done, 1);
        check("first_vld_lat", first_vld, 3);

        // Start in the DONE cycle must be ignored.
        start = poke;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < (chain ? 1 : 4); t++) begin
            if (t > 0) @(negedge clk);
            check_idle_outputs("tail");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_WORDS; i++) rom_mem[i] = model(i).dat;
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vld",  out_valid, 0);
        check("rst_dat",  out_data, 0);
        check("rst_idx",  out_idx, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check_idle_outputs("no_autostart");
            check("no_autostart_addr", rom_addr, 0);
        end

        run_pass(0, 0, 1'b0, -1, 1'b0);
        run_pass(1, 12, 1'b0, -1, 1'b0);
        run_pass(2, 0, 1'b1, -1, 1'b0);
        run_pass(2, 0, 1'b0, -1, 1'b1);
        run_pass(0, 0, 1'b0, -1, 1'b1);
        run_pass(0, 0, 1'b0, 7, 1'b0);
        run_pass(0, 0, 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
